alu_shift_seq: RTL and testbench
================================

Name: alu_shift_seq

Overview:
Multi-cycle sequencer that performs variable-amount shifts (SLL/SRL/SRA, 0..31 bits) using the 32-bit ALU's single-bit shift operations. It drives the ALU op and in0 once per cycle and feeds each result back until the shift amount is exhausted. It sits between the execute-stage decode and the shared ALU, with valid/ready handshakes on both request and response, and a synchronous flush for pipeline kills.

Parameters:
XLEN, 32, operand/result width
SHW, 5, shift-amount width (max shift 2^SHW-1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill; abandons any operation in progress
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_kind  in  2  00 SLL, 01 SRL, 10 SRA, 11 illegal
req_data  in  XLEN  operand to shift
req_shamt  in  SHW  shift amount
alu_op  out  3  ALU opcode: 7 SLL1, 6 SRL1, 4 SRA1, 0 when idle
alu_in0  out  XLEN  ALU operand, equal to the internal accumulator
alu_in1  out  XLEN  tied to 0 (ignored by the ALU for shifts)
alu_res  in  XLEN  ALU result, combinational from alu_op/alu_in0
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  XLEN  shifted result
rsp_err  out  1  set with rsp_valid when req_kind was 11

Behaviour:
- Reset (rst_n=0, async): state IDLE; acc, cnt, kind, err cleared. Outputs: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, alu_op=0, alu_in0=0.
- States: IDLE, SHIFT, DONE.
- IDLE: req_ready=1. When req_valid=1: acc<=req_data, cnt<=req_shamt, kind<=req_kind.
  - kind=11: err<=1, go to DONE, acc unchanged.
  - shamt=0: go to DONE.
  - Otherwise: go to SHIFT.
- SHIFT: req_ready=0; alu_op set from kind; alu_in0=acc. Each cycle acc<=alu_res and cnt<=cnt-1. When cnt==1, go to DONE on that edge, holding the final result.
- DONE: rsp_valid=1, rsp_data=acc, rsp_err=err, alu_op=0. Response is held stable until rsp_ready=1; then go to IDLE and clear err.
- req_ready is 0 in DONE, so no request is accepted in the same cycle as response handoff (one idle bubble between operations).
- Latency from accept edge to first rsp_valid cycle:
  - shamt=0 or illegal kind: 1 cycle.
  - Otherwise: shamt+1 cycles.
  - Maximum 32 cycles for XLEN=32.
- flush=1: takes priority over every transition. Next state IDLE; any pending response is dropped (rsp_valid falls next cycle). A request presented in the same cycle as flush is not accepted.
- Reset asserted mid-SHIFT or mid-DONE: immediate return to reset values; no response is produced.
- alu_op is 0 (AND) whenever the state is not SHIFT, so the ALU result is harmless.
- alu_in0 always equals acc, including in IDLE and DONE.
- Width rule: shifts are logical/arithmetic on the full XLEN. SRA requires alu_res to replicate bit XLEN-1. The sequencer does no masking of its own. The ALU must present a full XLEN-bit result.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode localparams: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=3, ALU_SRA1=4, ALU_NOR=5, ALU_SRL1=6, ALU_SLL1=7.
  - Shift-kind encodings SK_SLL/SK_SRL/SK_SRA/SK_ILL.
  - State enum for the sequencer.
- No sub-module. The ALU is instantiated alongside the sequencer by the parent, not inside it.
- The bench supplies a golden single-bit-shift ALU model with full 32-bit output.

Test Plan:
- SLL: req_data=0x0000_0001, shamt=31 -> rsp_data=0x8000_0000 exactly 32 cycles after accept; alu_op=7 for 31 consecutive cycles.
- SRA: req_data=0x8000_00F0, shamt=4 -> rsp_data=0xF800_000F after 5 cycles. SRL with the same inputs -> 0x0800_000F.
- shamt=0 and illegal kind: data=0x1234_5678, SLL shamt=0 -> rsp_data=0x1234_5678, rsp_err=0, 1 cycle. Kind=11 -> same data, rsp_err=1, alu_op stays 0.
- Backpressure: rsp_ready held 0 for 5 cycles in DONE -> rsp_valid/rsp_data stable and req_ready=0 throughout. A request offered during DONE is accepted only after the handoff, one cycle later.
- Flush: flush mid-SHIFT (SLL by 10 of 0x1, asserted at cycle 4) -> state IDLE, no rsp_valid ever. Flush in the same cycle as req_valid -> request not accepted, req_ready=1 next cycle.
- Async reset: assert rst_n=0 between clock edges during SHIFT -> all outputs at reset values immediately. After deassertion, a new SRL 0xFFFF_FFFF by 1 -> 0x7FFF_FFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, shift-kind encodings and sequencer state type.
package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_SRA1 = 3'd4;
  localparam logic [2:0] ALU_NOR  = 3'd5;
  localparam logic [2:0] ALU_SRL1 = 3'd6;
  localparam logic [2:0] ALU_SLL1 = 3'd7;

  typedef enum logic [1:0] {
    SK_SLL = 2'b00,
    SK_SRL = 2'b01,
    SK_SRA = 2'b10,
    SK_ILL = 2'b11
  } shift_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  function automatic logic [2:0] kind_to_op(shift_kind_e k);
    case (k)
      SK_SLL:  return ALU_SLL1;
      SK_SRL:  return ALU_SRL1;
      SK_SRA:  return ALU_SRA1;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_shift_seq.sv
// Variable-amount shift sequencer: steps the shared ALU one bit per cycle,
// feeding its result back into the accumulator until the amount is used up.
module alu_shift_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [XLEN-1:0] req_data,
  input  logic [SHW-1:0]  req_shamt,
  output logic [2:0]      alu_op,
  output logic [XLEN-1:0] alu_in0,
  output logic [XLEN-1:0] alu_in1,
  input  logic [XLEN-1:0] alu_res,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err
);

  seq_state_e      state_q;
  logic [XLEN-1:0] acc_q;
  logic [SHW-1:0]  cnt_q;
  shift_kind_e     kind_q;
  logic            err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      kind_q  <= SK_SLL;
      err_q   <= 1'b0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) begin
          acc_q  <= req_data;
          cnt_q  <= req_shamt;
          kind_q <= shift_kind_e'(req_kind);
          if (req_kind == SK_ILL) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else if (req_shamt == '0) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc_q <= alu_res;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) state_q <= ST_DONE;
        end
        ST_DONE: if (rsp_ready) begin
          state_q <= ST_IDLE;
          err_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state; the ALU sees AND outside SHIFT.
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_data  = (state_q == ST_DONE) ? acc_q : '0;
  assign rsp_err   = (state_q == ST_DONE) & err_q;
  assign alu_op    = (state_q == ST_SHIFT) ? kind_to_op(kind_q) : ALU_AND;
  assign alu_in0   = acc_q;
  assign alu_in1   = '0;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq: golden 1-bit ALU, transaction-level reference model,
// per-cycle compare, directed literal cases and randomized traffic.
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  req_kind;
  logic [31:0] req_data, alu_in0, alu_in1, alu_res, rsp_data;
  logic [4:0]  req_shamt;
  logic [2:0]  alu_op;

  int n_tests = 0;
  int n_fail  = 0;

  alu_shift_seq #(.XLEN(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_data(req_data), .req_shamt(req_shamt),
    .alu_op(alu_op), .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // golden ALU
  always_comb begin
    case (alu_op)
      3'd0: alu_res = alu_in0 & alu_in1;
      3'd1: alu_res = alu_in0 | alu_in1;
      3'd2: alu_res = alu_in0 + alu_in1;
      3'd3: alu_res = alu_in0 - alu_in1;
      3'd4: alu_res = {alu_in0[31], alu_in0[31:1]};
      3'd5: alu_res = ~(alu_in0 | alu_in1);
      3'd6: alu_res = {1'b0, alu_in0[31:1]};
      default: alu_res = {alu_in0[30:0], 1'b0};
    endcase
  end

  function automatic logic [31:0] ref_shift(logic [31:0] d, logic [1:0] k, int n);
    case (k)
      2'd0:    return d << n;
      2'd1:    return d >> n;
      2'd2:    return 32'($signed(d) >>> n);
      default: return d;
    endcase
  endfunction

  function automatic logic [2:0] ref_op(logic [1:0] k);
    case (k)
      2'd0: return 3'd7;
      2'd1: return 3'd6;
      2'd2: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: phase 0 idle, 1 shifting (m_k bits done so far), 2 response held.
  int         m_ph, m_k, m_sh;
  logic [31:0] m_data;
  logic [1:0]  m_kind;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_k <= 0; m_sh <= 0; m_data <= '0; m_kind <= 2'd0;
    end else if (flush) begin
      m_ph <= 0;
    end else if (m_ph == 0) begin
      if (req_valid) begin
        m_data <= req_data; m_kind <= req_kind; m_sh <= int'(req_shamt); m_k <= 0;
        m_ph   <= (req_kind == 2'd3 || req_shamt == 5'd0) ? 2 : 1;
      end
    end else if (m_ph == 1) begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_sh) m_ph <= 2;
    end else if (rsp_ready) begin
      m_ph <= 0;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(m_ph == 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_ph == 2));
    chk("alu_op",    32'(alu_op),    32'((m_ph == 1) ? ref_op(m_kind) : 3'd0));
    chk("alu_in0",   alu_in0,        ref_shift(m_data, m_kind, m_k));
    chk("alu_in1",   alu_in1,        32'd0);
    chk("rsp_err",   32'(rsp_err),   32'(m_ph == 2 && m_kind == 2'd3));
    if (m_ph == 2) chk("rsp_data", rsp_data, ref_shift(m_data, m_kind, m_k));
  end

  task automatic issue(input logic [1:0] k, input logic [31:0] d, input logic [4:0] s);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("issue_timeout", 32'(guard), 32'd0);
    #1;
    req_valid = 1'b1; req_kind = k; req_data = d; req_shamt = s;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output int ops);
    lat = 0; ops = 0;
    do begin
      @(negedge clk);
      lat++;
      if (alu_op != 3'd0) ops++;
    end while (!rsp_valid && lat < 100);
    if (lat >= 100) chk("rsp_timeout", 32'(lat), 32'd0);
  endtask

  task automatic handoff();
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run_op(string nm, input logic [1:0] k, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] ed, input logic ee,
                        input int elat, input int eops);
    int lat, ops;
    issue(k, d, s);
    wait_rsp(lat, ops);
    chk({nm, "_data"}, rsp_data, ed);
    chk({nm, "_err"},  32'(rsp_err), 32'(ee));
    chk({nm, "_lat"},  32'(lat), 32'(elat));
    chk({nm, "_ops"},  32'(ops), 32'(eops));
    handoff();
  endtask

  initial begin
    int lat, ops, seen;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_kind = 2'd0; req_data = '0; req_shamt = '0;
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  rsp_data, 32'd0);
    chk("rst_alu_op",    32'(alu_op), 32'd0);
    chk("rst_alu_in0",   alu_in0, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    run_op("sll31",   2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 32, 31);
    run_op("sra4",    2'd2, 32'h8000_00F0, 5'd4,  32'hF800_000F, 1'b0, 5, 4);
    run_op("srl4",    2'd1, 32'h8000_00F0, 5'd4,  32'h0800_000F, 1'b0, 5, 4);
    run_op("sh0",     2'd0, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1, 0);
    run_op("illegal", 2'd3, 32'h1234_5678, 5'd9,  32'h1234_5678, 1'b1, 1, 0);

    // backpressure with a request waiting behind the held response
    issue(2'd2, 32'hF000_0000, 5'd3);
    wait_rsp(lat, ops);
    #1 req_valid = 1'b1; req_kind = 2'd0; req_data = 32'hA5A5_0001; req_shamt = 5'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data",  rsp_data, 32'hFE00_0000);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    handoff();
    @(negedge clk);
    chk("bubble_ready", 32'(req_ready), 32'd1);
    chk("bubble_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("after_bubble_valid", 32'(rsp_valid), 32'd1);
    chk("after_bubble_data",  rsp_data, 32'hA5A5_0001);
    handoff();

    // flush mid-shift
    issue(2'd0, 32'h1, 5'd10);
    repeat (3) @(negedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("flush_no_rsp",   32'(seen), 32'd0);
    chk("flush_idle_rdy", 32'(req_ready), 32'd1);

    // flush alongside a request
    #1 flush = 1'b1; req_valid = 1'b1; req_kind = 2'd0; req_data = 32'h7; req_shamt = 5'd3;
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flushreq_ready", 32'(req_ready), 32'd1);
    chk("flushreq_op",    32'(alu_op), 32'd0);
    chk("flushreq_valid", 32'(rsp_valid), 32'd0);

    // async reset mid-shift
    issue(2'd0, 32'h3, 5'd20);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_op",    32'(alu_op), 32'd0);
    chk("arst_in0",   alu_in0, 32'd0);
    chk("arst_err",   32'(rsp_err), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    run_op("srl1_post", 2'd1, 32'hFFFF_FFFF, 5'd1, 32'h7FFF_FFFF, 1'b0, 2, 1);

    // randomized traffic, checked cycle by cycle against the reference
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      #1;
      req_valid = ($urandom_range(0, 1) == 1);
      req_kind  = 2'($urandom_range(0, 3));
      req_data  = $urandom;
      req_shamt = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      flush     = ($urandom_range(0, 49) == 0);
      rsp_ready = ($urandom_range(0, 2) == 0);
    end
    #1 req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
